// File: rtl/digtal_frame_tx.sv
// digtal_frame_tx
// ---------------
// Serial frame source for the digital receive/buffer chain. It sends 8N1 UART
// bytes at BAUD_Digtal and frames every group of Frame_Length bytes with an
// active-low chip select. Lead_Bits idle bit-times come before the first start
// bit and Trail_Bits idle bit-times follow the last stop bit. Bytes come from an
// upstream source over a valid/ready handshake, one byte per WAIT visit.
//
// Ports
//   Clock_29491200Hz  in   sole clock, rising edge
//   RST_n             in   synchronous active-low reset
//   Frame_Start       in   single-cycle frame request, honoured only in IDLE
//   Tx_Data[7:0]      in   byte to send
//   Tx_Valid          in   Tx_Data is valid
//   Tx_Ready          out  byte accepted on Tx_Valid && Tx_Ready (WAIT only)
//   Tx_Digtal         out  serial line, idle/mark = 1
//   CS_Digtal         out  active-low frame enable
//   Busy              out  high whenever the state is not IDLE
//   Frame_Done        out  one-cycle pulse on the first cycle back in IDLE
//   Underrun          out  sticky: a byte was due while Tx_Valid was low
module digtal_frame_tx #(
  parameter int CLOCK_Frequency = 29491200,
  parameter int BAUD_Digtal     = 921600,
  parameter int Frame_Length    = 256,
  parameter int Lead_Bits       = 2,
  parameter int Trail_Bits      = 2
) (
  input  logic       Clock_29491200Hz,
  input  logic       RST_n,
  input  logic       Frame_Start,
  input  logic [7:0] Tx_Data,
  input  logic       Tx_Valid,
  output logic       Tx_Ready,
  output logic       Tx_Digtal,
  output logic       CS_Digtal,
  output logic       Busy,
  output logic       Frame_Done,
  output logic       Underrun
);

  localparam int          BIT_DIV    = CLOCK_Frequency / BAUD_Digtal;
  localparam logic [15:0] BIT_LAST   = 16'(BIT_DIV - 1);
  localparam logic [15:0] FRAME_LEN  = 16'(Frame_Length);
  localparam logic [7:0]  LEAD_LAST  = 8'(Lead_Bits - 1);
  localparam logic [7:0]  TRAIL_LAST = 8'(Trail_Bits - 1);

  // Reject configurations that cannot produce jitter-free bit timing.
  if ((BIT_DIV < 4) || (BIT_DIV * BAUD_Digtal != CLOCK_Frequency)) begin : g_bad_div
    $error("digtal_frame_tx: CLOCK_Frequency/BAUD_Digtal must be an integer >= 4");
  end
  if ((Frame_Length < 1) || (Frame_Length > 65535)) begin : g_bad_len
    $error("digtal_frame_tx: Frame_Length must be 1..65535");
  end
  if ((Lead_Bits < 0) || (Lead_Bits > 255) || (Trail_Bits < 0) || (Trail_Bits > 255)) begin : g_bad_pad
    $error("digtal_frame_tx: Lead_Bits/Trail_Bits must be 0..255");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_WAIT,
    S_START,
    S_DATA,
    S_STOP,
    S_TRAIL
  } state_t;

  state_t      state;
  logic [15:0] bit_cnt;
  logic [2:0]  bit_idx;
  logic [15:0] byte_cnt;
  logic [7:0]  pad_cnt;
  logic [7:0]  shreg;
  logic        bit_end;
  logic        hs;

  assign bit_end = (bit_cnt == BIT_LAST);
  assign hs      = Tx_Valid && Tx_Ready;

  // Shift register holds payload only, so it carries no reset. It loads on the
  // handshake and shifts right at the end of the start bit and of each data bit,
  // keeping the next bit to transmit in shreg[0].
  always_ff @(posedge Clock_29491200Hz) begin
    if (hs) begin
      shreg <= Tx_Data;
    end else if (((state == S_START) || (state == S_DATA)) && bit_end) begin
      shreg <= {1'b0, shreg[7:1]};
    end
  end

  // Control FSM. All outputs are registered and change together with the
  // state, so the line level always belongs to the state being entered.
  always_ff @(posedge Clock_29491200Hz) begin
    if (!RST_n) begin
      state      <= S_IDLE;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      byte_cnt   <= '0;
      pad_cnt    <= '0;
      Tx_Ready   <= 1'b0;
      Tx_Digtal  <= 1'b1;
      CS_Digtal  <= 1'b1;
      Busy       <= 1'b0;
      Frame_Done <= 1'b0;
      Underrun   <= 1'b0;
    end else begin
      Frame_Done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Frame_Start) begin
            Underrun  <= 1'b0;
            byte_cnt  <= '0;
            bit_cnt   <= '0;
            pad_cnt   <= '0;
            CS_Digtal <= 1'b0;
            Busy      <= 1'b1;
            if (Lead_Bits == 0) begin
              state    <= S_WAIT;
              Tx_Ready <= 1'b1;
            end else begin
              state <= S_LEAD;
            end
          end
        end

        S_LEAD: begin
          if (bit_end) begin
            bit_cnt <= '0;
            if (pad_cnt == LEAD_LAST) begin
              pad_cnt  <= '0;
              state    <= S_WAIT;
              Tx_Ready <= 1'b1;
            end else begin
              pad_cnt <= pad_cnt + 8'd1;
            end
          end else begin
            bit_cnt <= bit_cnt + 16'd1;
          end
        end

        // Waits indefinitely for data; every starved cycle marks an underrun.
        S_WAIT: begin
          if (hs) begin
            byte_cnt  <= byte_cnt + 16'd1;
            bit_cnt   <= '0;
            Tx_Ready  <= 1'b0;
            Tx_Digtal <= 1'b0;
            state     <= S_START;
          end else begin
            Underrun <= 1'b1;
          end
        end

        S_START: begin
          if (bit_end) begin
            bit_cnt   <= '0;
            bit_idx   <= '0;
            Tx_Digtal <= shreg[0];
            state     <= S_DATA;
          end else begin
            bit_cnt <= bit_cnt + 16'd1;
          end
        end

        S_DATA: begin
          if (bit_end) begin
            bit_cnt <= '0;
            if (bit_idx == 3'd7) begin
              Tx_Digtal <= 1'b1;
              state     <= S_STOP;
            end else begin
              bit_idx   <= bit_idx + 3'd1;
              Tx_Digtal <= shreg[0];
            end
          end else begin
            bit_cnt <= bit_cnt + 16'd1;
          end
        end

        S_STOP: begin
          if (bit_end) begin
            bit_cnt <= '0;
            if (byte_cnt < FRAME_LEN) begin
              state    <= S_WAIT;
              Tx_Ready <= 1'b1;
            end else if (Trail_Bits == 0) begin
              state      <= S_IDLE;
              CS_Digtal  <= 1'b1;
              Busy       <= 1'b0;
              Frame_Done <= 1'b1;
            end else begin
              pad_cnt <= '0;
              state   <= S_TRAIL;
            end
          end else begin
            bit_cnt <= bit_cnt + 16'd1;
          end
        end

        S_TRAIL: begin
          if (bit_end) begin
            bit_cnt <= '0;
            if (pad_cnt == TRAIL_LAST) begin
              pad_cnt    <= '0;
              state      <= S_IDLE;
              CS_Digtal  <= 1'b1;
              Busy       <= 1'b0;
              Frame_Done <= 1'b1;
            end else begin
              pad_cnt <= pad_cnt + 8'd1;
            end
          end else begin
            bit_cnt <= bit_cnt + 16'd1;
          end
        end

        default: begin
          state     <= S_IDLE;
          Tx_Ready  <= 1'b0;
          Tx_Digtal <= 1'b1;
          CS_Digtal <= 1'b1;
          Busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_digtal_frame_tx.sv
// Bench for digtal_frame_tx. Instance "dut" uses a 4-byte frame with 2 lead
// and 2 trail bit-times; instance "dut_b" uses a 1-byte frame with no padding.
// Sample index k counts rising edges from the one that captures Frame_Start
// (k=0); every sample is taken #1 after its edge.
module tb_digtal_frame_tx;
  localparam int BD = 32;
  localparam int NLOG = 2300;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, fs, tvalid;
  logic [7:0] tdata;
  logic       trdy, txd, cs, busy, done, unr;

  logic       rst_n_b, fs_b, tvalid_b;
  logic [7:0] tdata_b;
  logic       trdy_b, txd_b, cs_b, busy_b, done_b, unr_b;

  digtal_frame_tx #(.Frame_Length(4), .Lead_Bits(2), .Trail_Bits(2)) dut (
    .Clock_29491200Hz(clk), .RST_n(rst_n), .Frame_Start(fs), .Tx_Data(tdata),
    .Tx_Valid(tvalid), .Tx_Ready(trdy), .Tx_Digtal(txd), .CS_Digtal(cs),
    .Busy(busy), .Frame_Done(done), .Underrun(unr));

  digtal_frame_tx #(.Frame_Length(1), .Lead_Bits(0), .Trail_Bits(0)) dut_b (
    .Clock_29491200Hz(clk), .RST_n(rst_n_b), .Frame_Start(fs_b), .Tx_Data(tdata_b),
    .Tx_Valid(tvalid_b), .Tx_Ready(trdy_b), .Tx_Digtal(txd_b), .CS_Digtal(cs_b),
    .Busy(busy_b), .Frame_Done(done_b), .Underrun(unr_b));

  int checks = 0;
  int failures = 0;

  logic [7:0] frame [0:3];
  logic tx_l [0:NLOG-1];
  logic cs_l [0:NLOG-1];
  logic rdy_l[0:NLOG-1];
  logic bsy_l[0:NLOG-1];
  logic dn_l [0:NLOG-1];
  logic ur_l [0:NLOG-1];

  typedef struct {
    int   k;
    logic tx;
    logic cs;
    logic rdy;
    logic bsy;
    logic dn;
  } vec_t;
  vec_t vt [$];

  task automatic chk(input string name, input int k, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s k=%0d actual=%0h expected=%0h", name, k, act, exp);
    end
  endtask

  // Runs one frame on "dut" and logs outputs for n samples.
  // vbyte: Tx_Valid drops once the byte index reaches vbyte, for gap cycles.
  // rej: sample index where a stray Frame_Start is driven; rstk: reset index.
  task automatic capture(input int n, input int vbyte, input int gap, input int rej, input int rstk);
    int   idx;
    int   kon;
    logic hs;
    logic dropped;
    idx = 0; kon = -1; hs = 1'b0; dropped = 1'b0;
    tdata = frame[0];
    tvalid = 1'b1;
    @(negedge clk);
    fs = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (hs) idx++;
      tx_l[k] = txd; cs_l[k] = cs; rdy_l[k] = trdy;
      bsy_l[k] = busy; dn_l[k] = done; ur_l[k] = unr;
      tdata = frame[idx % 4];
      fs = (k == rej);
      rst_n = (k != rstk);
      if (!dropped && idx == vbyte) begin
        dropped = 1'b1;
        tvalid = 1'b0;
        kon = k + gap;
      end
      if (k == kon) tvalid = 1'b1;
      hs = trdy && tvalid;
    end
    fs = 1'b0;
    tvalid = 1'b1;
  endtask

  function automatic int cs_low_cnt(input int n);
    int c = 0;
    for (int k = 0; k < n; k++) if (cs_l[k] == 1'b0) c++;
    return c;
  endfunction

  function automatic int done_cnt(input int n);
    int c = 0;
    for (int k = 0; k < n; k++) if (dn_l[k] == 1'b1) c++;
    return c;
  endfunction

  // Line level at the middle of data bit j of a byte whose start bit begins at s.
  task automatic chk_byte(input string name, input int s, input logic [7:0] b);
    logic [7:0] v;
    v = b;
    for (int j = 0; j < 8; j++)
      chk(name, s + BD * (j + 1) + BD / 2, {15'd0, tx_l[s + BD * (j + 1) + BD / 2]}, {15'd0, v[j]});
  endtask

  initial begin
    int bad;
    logic tb_tx [0:699];
    logic tb_cs [0:699];
    logic tb_rdy[0:699];
    logic tb_bsy[0:699];
    logic tb_dn [0:699];
    logic [7:0] a5;

    frame[0] = 8'hEB; frame[1] = 8'h90; frame[2] = 8'h90; frame[3] = 8'hEB;
    a5 = 8'hA5;

    // Expected waveform landmarks for the basic frame (lead 64, byte period 321).
    vt.push_back('{0,    1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
    vt.push_back('{63,   1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
    vt.push_back('{64,   1'b1, 1'b0, 1'b1, 1'b1, 1'b0});
    vt.push_back('{65,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    vt.push_back('{96,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    vt.push_back('{97,   1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
    vt.push_back('{129,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
    vt.push_back('{161,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    vt.push_back('{193,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
    vt.push_back('{225,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    vt.push_back('{257,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
    vt.push_back('{289,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
    vt.push_back('{321,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
    vt.push_back('{353,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
    vt.push_back('{384,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
    vt.push_back('{385,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0});
    vt.push_back('{386,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    vt.push_back('{514,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    vt.push_back('{546,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
    vt.push_back('{1411, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
    vt.push_back('{1412, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1});
    vt.push_back('{1413, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});

    rst_n = 1'b0; fs = 1'b0; tvalid = 1'b1; tdata = 8'h00;
    rst_n_b = 1'b0; fs_b = 1'b0; tvalid_b = 1'b1; tdata_b = a5;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", 0, {15'd0, txd}, 16'd1);
    chk("rst_cs", 0, {15'd0, cs}, 16'd1);
    chk("rst_rdy", 0, {15'd0, trdy}, 16'd0);
    chk("rst_busy", 0, {15'd0, busy}, 16'd0);
    chk("rst_done", 0, {15'd0, done}, 16'd0);
    chk("rst_unr", 0, {15'd0, unr}, 16'd0);
    chk("rst_b_cs", 0, {15'd0, cs_b}, 16'd1);
    chk("rst_b_tx", 0, {15'd0, txd_b}, 16'd1);
    rst_n = 1'b1; rst_n_b = 1'b1;
    repeat (2) @(posedge clk);

    // Reset mid-frame: starve the first WAIT (k 64..100), byte 0 starts at 101,
    // data bit 4 spans 261..292, reset is sampled at edge k=271.
    capture(400, 0, 100, -1, 270);
    chk("rm_unr_set", 200, {15'd0, ur_l[200]}, 16'd1);
    chk("rm_start", 101, {15'd0, tx_l[101]}, 16'd0);
    chk("rm_bit4", 265, {15'd0, tx_l[265]}, 16'd0);
    chk("rm_tx", 271, {15'd0, tx_l[271]}, 16'd1);
    chk("rm_cs", 271, {15'd0, cs_l[271]}, 16'd1);
    chk("rm_busy", 271, {15'd0, bsy_l[271]}, 16'd0);
    chk("rm_unr", 271, {15'd0, ur_l[271]}, 16'd0);
    chk("rm_rdy", 271, {15'd0, rdy_l[271]}, 16'd0);
    chk("rm_idle", 399, {15'd0, cs_l[399]}, 16'd1);
    chk("rm_nodone", 0, 16'(done_cnt(400)), 16'd0);

    // Basic frame after the reset: table plus per-bit data check.
    capture(1500, -1, 0, -1, -1);
    foreach (vt[i]) begin
      chk("vec_tx", vt[i].k, {15'd0, tx_l[vt[i].k]}, {15'd0, vt[i].tx});
      chk("vec_cs", vt[i].k, {15'd0, cs_l[vt[i].k]}, {15'd0, vt[i].cs});
      chk("vec_rdy", vt[i].k, {15'd0, rdy_l[vt[i].k]}, {15'd0, vt[i].rdy});
      chk("vec_busy", vt[i].k, {15'd0, bsy_l[vt[i].k]}, {15'd0, vt[i].bsy});
      chk("vec_done", vt[i].k, {15'd0, dn_l[vt[i].k]}, {15'd0, vt[i].dn});
    end
    for (int b = 0; b < 4; b++) chk_byte("basic_data", 65 + 321 * b, frame[b]);
    chk("basic_cs_low", 0, 16'(cs_low_cnt(1500)), 16'd1412);
    chk("basic_done_cnt", 0, 16'(done_cnt(1500)), 16'd1);
    chk("basic_unr", 1499, {15'd0, ur_l[1499]}, 16'd0);

    // Busy rejection: stray Frame_Start during byte 2 changes nothing.
    capture(1500, -1, 0, 800, -1);
    chk("rej_cs_low", 0, 16'(cs_low_cnt(1500)), 16'd1412);
    chk("rej_done_cnt", 0, 16'(done_cnt(1500)), 16'd1);
    chk("rej_done_at", 1412, {15'd0, dn_l[1412]}, 16'd1);
    chk_byte("rej_data3", 65 + 321 * 3, frame[3]);

    // Underrun: Tx_Valid low from k=386 to 1385, byte 2 WAIT first at k=706.
    capture(2200, 2, 1000, -1, -1);
    bad = 0;
    for (int k = 706; k <= 1386; k++) if (tx_l[k] !== 1'b1 || cs_l[k] !== 1'b0) bad++;
    chk("ur_gap_line", 706, 16'(bad), 16'd0);
    chk("ur_before", 706, {15'd0, ur_l[706]}, 16'd0);
    chk("ur_set", 707, {15'd0, ur_l[707]}, 16'd1);
    chk("ur_sticky", 2150, {15'd0, ur_l[2150]}, 16'd1);
    chk("ur_rdy_gap", 1000, {15'd0, rdy_l[1000]}, 16'd1);
    chk("ur_idle_line", 1386, {15'd0, tx_l[1386]}, 16'd1);
    chk("ur_resume", 1387, {15'd0, tx_l[1387]}, 16'd0);
    chk_byte("ur_data2", 1387, frame[2]);
    chk("ur_cs_low", 0, 16'(cs_low_cnt(2200)), 16'd2092);
    chk("ur_done_cnt", 0, 16'(done_cnt(2200)), 16'd1);

    // One-byte frame, no padding; second Frame_Start in the Frame_Done cycle.
    @(negedge clk);
    fs_b = 1'b1;
    for (int k = 0; k < 700; k++) begin
      @(posedge clk);
      #1;
      tb_tx[k] = txd_b; tb_cs[k] = cs_b; tb_rdy[k] = trdy_b;
      tb_bsy[k] = busy_b; tb_dn[k] = done_b;
      fs_b = (k == 321);
    end
    fs_b = 1'b0;
    chk("b_wait_rdy", 0, {15'd0, tb_rdy[0]}, 16'd1);
    chk("b_wait_cs", 0, {15'd0, tb_cs[0]}, 16'd0);
    chk("b_wait_tx", 0, {15'd0, tb_tx[0]}, 16'd1);
    chk("b_start", 1, {15'd0, tb_tx[1]}, 16'd0);
    chk("b_start_rdy", 1, {15'd0, tb_rdy[1]}, 16'd0);
    chk("b_start_end", 32, {15'd0, tb_tx[32]}, 16'd0);
    for (int j = 0; j < 8; j++)
      chk("b_data", 1 + BD * (j + 1) + BD / 2, {15'd0, tb_tx[1 + BD * (j + 1) + BD / 2]}, {15'd0, a5[j]});
    chk("b_stop_last", 320, {15'd0, tb_tx[320]}, 16'd1);
    chk("b_cs_last", 320, {15'd0, tb_cs[320]}, 16'd0);
    chk("b_cs_up", 321, {15'd0, tb_cs[321]}, 16'd1);
    chk("b_done", 321, {15'd0, tb_dn[321]}, 16'd1);
    chk("b_busy_low", 321, {15'd0, tb_bsy[321]}, 16'd0);
    bad = 0;
    for (int k = 0; k <= 321; k++) if (tb_cs[k] == 1'b0) bad++;
    chk("b_cs_low", 0, 16'(bad), 16'd321);
    chk("b_restart_cs", 322, {15'd0, tb_cs[322]}, 16'd0);
    chk("b_restart_busy", 322, {15'd0, tb_bsy[322]}, 16'd1);
    chk("b_restart_done", 322, {15'd0, tb_dn[322]}, 16'd0);
    chk("b_second_done", 643, {15'd0, tb_dn[643]}, 16'd1);
    chk("b_unr", 0, {15'd0, unr_b}, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
